// File: rtl/sopc_2_timer_host.sv
// sopc_2_timer_host: Avalon-MM master that drives the interval timer slave
// without a CPU. It programs the 32-bit period, starts continuous interrupt
// mode, clears status on every irq (counting ticks), and on request takes a
// counter snapshot or stops the timer.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_period/cfg_start  period value and start pulse (sampled in IDLE)
//   cfg_stop, snap_req    stop / snapshot request pulses (held pending)
//   avm_*                 Avalon-MM master to the timer s1 port, no waitrequest
//   irq_in                timer irq, level
//   busy                  timer programmed/running or stop in progress
//   tick, tick_count      pulse and count per serviced timeout
//   snap_valid/snap_value snapshot pulse and captured 32-bit counter
//   err                   pulse when cfg_start is rejected (zero period)
module sopc_2_timer_host #(
  parameter int unsigned TICK_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              snap_req,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              irq_in,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic              err
);

  localparam int unsigned WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RD_LAT - 1);

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERIODL = 3'd2;
  localparam logic [2:0] A_PERIODH = 3'd3;
  localparam logic [2:0] A_SNAPL   = 3'd4;
  localparam logic [2:0] A_SNAPH   = 3'd5;

  localparam logic [15:0] CTRL_RUN  = 16'h0007;  // START | CONT | ITO
  localparam logic [15:0] CTRL_STOP = 16'h0008;  // STOP

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST,
    SNAP_WR, RD_L, WAIT_L, RD_H, WAIT_H, WR_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                stop_pend_q, stop_pend_d;
  logic                snap_pend_q, snap_pend_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

  logic [2:0]          avm_address_d;
  logic                avm_chipselect_d;
  logic                avm_write_n_d;
  logic [15:0]         avm_writedata_d;
  logic                busy_d;
  logic                tick_d;
  logic [TICK_W-1:0]   tick_count_d;
  logic                snap_valid_d;
  logic [31:0]         snap_value_d;
  logic                err_d;

  // State and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      period_q    <= '0;
      stop_pend_q <= 1'b0;
      snap_pend_q <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      stop_pend_q <= stop_pend_d;
      snap_pend_q <= snap_pend_d;
      wcnt_q      <= wcnt_d;
    end
  end

  // Next state, period latch, pending request flags, read-wait counter
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    wcnt_d      = wcnt_q;
    // Requests outside IDLE are sticky; repeats merge into one
    stop_pend_d = stop_pend_q | (cfg_stop & (state_q != IDLE));
    snap_pend_d = snap_pend_q | (snap_req & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        snap_pend_d = 1'b0;
        if (cfg_start && (cfg_period != 32'd0)) begin
          period_d = cfg_period;
          state_d  = WR_PL;
        end
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTRL;
      WR_CTRL: state_d = RUN;
      RUN: begin
        if (stop_pend_q) begin
          // Stop also discards any snapshot still waiting
          stop_pend_d = 1'b0;
          snap_pend_d = 1'b0;
          state_d     = WR_STOP;
        end else if (irq_in) begin
          state_d = CLR_ST;
        end else if (snap_pend_q) begin
          snap_pend_d = 1'b0;
          state_d     = SNAP_WR;
        end
      end
      CLR_ST:  state_d = RUN;
      SNAP_WR: state_d = RD_L;
      RD_L: begin
        wcnt_d  = '0;
        state_d = WAIT_L;
      end
      WAIT_L: begin
        if (wcnt_q == WCNT_LAST) state_d = RD_H;
        else                     wcnt_d  = wcnt_q + WCNT_W'(1);
      end
      RD_H: begin
        wcnt_d  = '0;
        state_d = WAIT_H;
      end
      WAIT_H: begin
        if (wcnt_q == WCNT_LAST) state_d = RUN;
        else                     wcnt_d  = wcnt_q + WCNT_W'(1);
      end
      WR_STOP: begin
        stop_pend_d = 1'b0;
        snap_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values: bus command follows the state being entered so the
  // registered command is on the bus exactly during that state's cycle
  always_comb begin
    avm_chipselect_d = 1'b0;
    avm_write_n_d    = 1'b1;
    avm_address_d    = 3'd0;
    avm_writedata_d  = 16'h0000;
    busy_d           = (state_d != IDLE);
    tick_d           = 1'b0;
    tick_count_d     = tick_count;
    snap_valid_d     = 1'b0;
    snap_value_d     = snap_value;
    err_d            = (state_q == IDLE) && cfg_start && (cfg_period == 32'd0);

    unique case (state_d)
      WR_PL: begin
        avm_chipselect_d = 1'b1;
        avm_write_n_d    = 1'b0;
        avm_address_d    = A_PERIODL;
        avm_writedata_d  = period_d[15:0];
      end
      WR_PH: begin
        avm_chipselect_d = 1'b1;
        avm_write_n_d    = 1'b0;
        avm_address_d    = A_PERIODH;
        avm_writedata_d  = period_d[31:16];
      end
      WR_CTRL: begin
        avm_chipselect_d = 1'b1;
        avm_write_n_d    = 1'b0;
        avm_address_d    = A_CONTROL;
        avm_writedata_d  = CTRL_RUN;
      end
      CLR_ST: begin
        avm_chipselect_d = 1'b1;
        avm_write_n_d    = 1'b0;
        avm_address_d    = A_STATUS;
        tick_d           = 1'b1;
        tick_count_d     = tick_count + TICK_W'(1);
      end
      SNAP_WR: begin
        avm_chipselect_d = 1'b1;
        avm_write_n_d    = 1'b0;
        avm_address_d    = A_SNAPL;
      end
      RD_L: begin
        avm_chipselect_d = 1'b1;
        avm_address_d    = A_SNAPL;
      end
      RD_H: begin
        avm_chipselect_d = 1'b1;
        avm_address_d    = A_SNAPH;
      end
      WR_STOP: begin
        avm_chipselect_d = 1'b1;
        avm_write_n_d    = 1'b0;
        avm_address_d    = A_CONTROL;
        avm_writedata_d  = CTRL_STOP;
      end
      default: ;
    endcase

    // Read data is valid on the last wait cycle of each half
    if ((state_q == WAIT_L) && (wcnt_q == WCNT_LAST)) begin
      snap_value_d[15:0] = avm_readdata;
    end
    if ((state_q == WAIT_H) && (wcnt_q == WCNT_LAST)) begin
      snap_value_d[31:16] = avm_readdata;
      snap_valid_d        = 1'b1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 3'd0;
      avm_writedata  <= 16'h0000;
      busy           <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      snap_valid     <= 1'b0;
      snap_value     <= 32'd0;
      err            <= 1'b0;
    end else begin
      avm_chipselect <= avm_chipselect_d;
      avm_write_n    <= avm_write_n_d;
      avm_address    <= avm_address_d;
      avm_writedata  <= avm_writedata_d;
      busy           <= busy_d;
      tick           <= tick_d;
      tick_count     <= tick_count_d;
      snap_valid     <= snap_valid_d;
      snap_value     <= snap_value_d;
      err            <= err_d;
    end
  end

endmodule
